// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks the register mask lowest-index first,
// issuing one memory access per selected register at consecutive addresses.
module lmsm_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        is_store,
   input  logic [15:0] base_addr,
   input  logic [7:0]  reg_mask,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   input  logic [15:0] rf_rdata,
   output logic        busy,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic [2:0]  rf_addr,
   output logic        rf_we,
   output logic [15:0] rf_wdata,
   output logic        done,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state, state_d;
   logic        is_store_q;
   logic [15:0] addr_ptr;
   logic [7:0]  rem_mask;
   logic [7:0]  mask_next;
   logic [2:0]  sel_idx;
   logic        load;
   logic        advance;

   // Handshake: mem_req/mem_addr/mem_we/mem_wdata are held while in ACCESS
   // and the access completes on any cycle where mem_req and mem_ack are both 1.

   always_comb begin
      sel_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rem_mask[i]) sel_idx = 3'(i);
      end
      mask_next = rem_mask & ~(8'd1 << sel_idx);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         is_store_q <= 1'b0;
         addr_ptr   <= 16'd0;
         rem_mask   <= 8'd0;
      end else if (load) begin
         is_store_q <= is_store;
         addr_ptr   <= base_addr;
         rem_mask   <= reg_mask;
      end else if (advance) begin
         rem_mask   <= mask_next;
         addr_ptr   <= addr_ptr + 16'd1;
      end
   end

   always_comb begin
      state_d   = state;
      load      = 1'b0;
      advance   = 1'b0;
      busy      = 1'b0;
      stall     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 16'd0;
      mem_wdata = 16'd0;
      rf_addr   = 3'd0;
      rf_we     = 1'b0;
      rf_wdata  = 16'd0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            // Gated with reset_n so no output rises while reset is held.
            stall = start & reset_n;
            if (start) begin
               if (reg_mask != 8'd0) begin
                  state_d = ACCESS;
                  load    = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         ACCESS: begin
            busy      = 1'b1;
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = is_store_q;
            mem_addr  = addr_ptr;
            mem_wdata = rf_rdata;
            rf_addr   = sel_idx;
            if (mem_ack) begin
               advance  = 1'b1;
               rf_we    = ~is_store_q;
               rf_wdata = is_store_q ? 16'd0 : mem_rdata;
               if (mask_next == 8'd0) state_d = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            stall   = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer with a small register-file model.
module tb_lmsm_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        is_store;
   logic [15:0] base_addr;
   logic [7:0]  reg_mask;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] rf_rdata;
   logic        busy, stall, mem_req, mem_we, rf_we, done;
   logic [15:0] mem_addr, mem_wdata, rf_wdata;
   logic [2:0]  rf_addr;
   logic [1:0]  dbg_state;

   logic [15:0] rf_mem [8];
   int          tests;
   int          failed;

   lmsm_sequencer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .is_store  (is_store),
      .base_addr (base_addr),
      .reg_mask  (reg_mask),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .rf_rdata  (rf_rdata),
      .busy      (busy),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .rf_addr   (rf_addr),
      .rf_we     (rf_we),
      .rf_wdata  (rf_wdata),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // register file model
   assign rf_rdata = rf_mem[rf_addr];
   always @(posedge clk) begin
      if (rf_we) rf_mem[rf_addr] <= rf_wdata;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag, input logic exp_stall, input logic exp_busy,
                            input logic exp_done);
      check({tag, ".busy"},      16'(busy),      16'(exp_busy));
      check({tag, ".stall"},     16'(stall),     16'(exp_stall));
      check({tag, ".done"},      16'(done),      16'(exp_done));
      check({tag, ".mem_req"},   16'(mem_req),   16'd0);
      check({tag, ".mem_we"},    16'(mem_we),    16'd0);
      check({tag, ".mem_addr"},  mem_addr,       16'd0);
      check({tag, ".mem_wdata"}, mem_wdata,      16'd0);
      check({tag, ".rf_addr"},   16'(rf_addr),   16'd0);
      check({tag, ".rf_we"},     16'(rf_we),     16'd0);
      check({tag, ".rf_wdata"},  rf_wdata,       16'd0);
   endtask

   task automatic chk_access(input string tag, input logic exp_we, input logic [15:0] exp_addr,
                             input logic [15:0] exp_wdata, input logic [2:0] exp_ra,
                             input logic exp_rfwe, input logic [15:0] exp_rfwd);
      check({tag, ".busy"},      16'(busy),    16'd1);
      check({tag, ".stall"},     16'(stall),   16'd1);
      check({tag, ".done"},      16'(done),    16'd0);
      check({tag, ".mem_req"},   16'(mem_req), 16'd1);
      check({tag, ".mem_we"},    16'(mem_we),  16'(exp_we));
      check({tag, ".mem_addr"},  mem_addr,     exp_addr);
      check({tag, ".mem_wdata"}, mem_wdata,    exp_wdata);
      check({tag, ".rf_addr"},   16'(rf_addr), 16'(exp_ra));
      check({tag, ".rf_we"},     16'(rf_we),   16'(exp_rfwe));
      check({tag, ".rf_wdata"},  rf_wdata,     exp_rfwd);
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      for (int i = 0; i < 8; i++) rf_mem[i] = 16'(16'h1111 * i);
      reset_n   = 1'b0;
      start     = 1'b1;
      is_store  = 1'b0;
      base_addr = 16'h0000;
      reg_mask  = 8'h00;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;

      // reset holds every output low, even with start asserted
      #2;
      chk_quiet("rst0", 1'b0, 1'b0, 1'b0);
      step();
      chk_quiet("rst1", 1'b0, 1'b0, 1'b0);

      // LM base 0x0010 mask 0x05, ack every cycle; start right after reset release
      reset_n   = 1'b1;
      start     = 1'b1;
      base_addr = 16'h0010;
      reg_mask  = 8'h05;
      #1;
      check("lm1.start_stall", 16'(stall), 16'd1);
      check("lm1.start_busy",  16'(busy),  16'd0);
      check("lm1.start_req",   16'(mem_req), 16'd0);
      step();
      start     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 16'hAAAA;
      #1;
      chk_access("lm1.a0", 1'b0, 16'h0010, 16'h0000, 3'd0, 1'b1, 16'hAAAA);
      step();
      mem_rdata = 16'h5555;
      #1;
      chk_access("lm1.a1", 1'b0, 16'h0011, 16'h2222, 3'd2, 1'b1, 16'h5555);
      step();
      mem_ack = 1'b0;
      #1;
      chk_quiet("lm1.done", 1'b1, 1'b1, 1'b1);
      step();
      chk_quiet("lm1.idle", 1'b0, 1'b0, 1'b0);
      check("lm1.r0", rf_mem[0], 16'hAAAA);
      check("lm1.r2", rf_mem[2], 16'h5555);

      // SM base 0x0100 mask 0x81, three wait cycles per access
      start     = 1'b1;
      is_store  = 1'b1;
      base_addr = 16'h0100;
      reg_mask  = 8'h81;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_access($sformatf("sm.w0_%0d", k), 1'b1, 16'h0100, 16'hAAAA, 3'd0, 1'b0, 16'h0000);
         step();
      end
      mem_ack = 1'b1;
      #1;
      chk_access("sm.a0", 1'b1, 16'h0100, 16'hAAAA, 3'd0, 1'b0, 16'h0000);
      step();
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_access($sformatf("sm.w1_%0d", k), 1'b1, 16'h0101, 16'h7777, 3'd7, 1'b0, 16'h0000);
         step();
      end
      mem_ack = 1'b1;
      #1;
      chk_access("sm.a1", 1'b1, 16'h0101, 16'h7777, 3'd7, 1'b0, 16'h0000);
      step();
      mem_ack = 1'b0;
      #1;
      chk_quiet("sm.done", 1'b1, 1'b1, 1'b1);
      step();
      // stray ack while idle must not start anything
      mem_ack = 1'b1;
      #1;
      chk_quiet("stray_ack", 1'b0, 1'b0, 1'b0);
      step();
      mem_ack = 1'b0;
      #1;
      chk_quiet("stray_ack2", 1'b0, 1'b0, 1'b0);

      // LM base 0xFFFF mask 0x03: address wraps
      start     = 1'b1;
      is_store  = 1'b0;
      base_addr = 16'hFFFF;
      reg_mask  = 8'h03;
      step();
      start     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 16'h1111;
      #1;
      chk_access("wrap.a0", 1'b0, 16'hFFFF, 16'hAAAA, 3'd0, 1'b1, 16'h1111);
      step();
      mem_rdata = 16'h2222;
      #1;
      chk_access("wrap.a1", 1'b0, 16'h0000, 16'h1111, 3'd1, 1'b1, 16'h2222);
      step();
      mem_ack = 1'b0;
      #1;
      chk_quiet("wrap.done", 1'b1, 1'b1, 1'b1);
      step();

      // empty mask: straight to DONE
      start    = 1'b1;
      reg_mask = 8'h00;
      #1;
      check("empty.start_stall", 16'(stall),   16'd1);
      check("empty.start_req",   16'(mem_req), 16'd0);
      step();
      start = 1'b0;
      #1;
      chk_quiet("empty.done", 1'b1, 1'b1, 1'b1);
      step();
      chk_quiet("empty.idle", 1'b0, 1'b0, 1'b0);

      // SM mask 0xFF, reset asserted after the third ack
      start     = 1'b1;
      is_store  = 1'b1;
      base_addr = 16'h0200;
      reg_mask  = 8'hFF;
      step();
      start   = 1'b0;
      mem_ack = 1'b1;
      #1;
      chk_access("rsm.a0", 1'b1, 16'h0200, 16'h1111, 3'd0, 1'b0, 16'h0000);
      step();
      chk_access("rsm.a1", 1'b1, 16'h0201, 16'h2222, 3'd1, 1'b0, 16'h0000);
      step();
      chk_access("rsm.a2", 1'b1, 16'h0202, 16'h5555, 3'd2, 1'b0, 16'h0000);
      step();
      chk_access("rsm.a3", 1'b1, 16'h0203, 16'h3333, 3'd3, 1'b0, 16'h0000);
      #2;
      reset_n = 1'b0;
      #1;
      chk_quiet("rsm.async", 1'b0, 1'b0, 1'b0);
      check("rsm.state", 16'(dbg_state), 16'd0);
      step();
      chk_quiet("rsm.held", 1'b0, 1'b0, 1'b0);
      mem_ack = 1'b0;
      reset_n = 1'b1;
      #1;
      chk_quiet("rsm.released", 1'b0, 1'b0, 1'b0);
      step();
      chk_quiet("rsm.still_idle", 1'b0, 1'b0, 1'b0);
      start     = 1'b1;
      base_addr = 16'h0300;
      reg_mask  = 8'h02;
      step();
      start   = 1'b0;
      mem_ack = 1'b1;
      #1;
      chk_access("rsm.re_a0", 1'b1, 16'h0300, 16'h2222, 3'd1, 1'b0, 16'h0000);
      step();
      mem_ack = 1'b0;
      #1;
      chk_quiet("rsm.re_done", 1'b1, 1'b1, 1'b1);
      step();

      // second start mid-sequence and a start during DONE are both ignored
      start     = 1'b1;
      is_store  = 1'b0;
      base_addr = 16'h0400;
      reg_mask  = 8'h06;
      step();
      start     = 1'b1;
      is_store  = 1'b1;
      base_addr = 16'h0800;
      reg_mask  = 8'h01;
      #1;
      chk_access("ign.w0", 1'b0, 16'h0400, 16'h2222, 3'd1, 1'b0, 16'h0000);
      step();
      start     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 16'hBEEF;
      #1;
      chk_access("ign.a0", 1'b0, 16'h0400, 16'h2222, 3'd1, 1'b1, 16'hBEEF);
      step();
      mem_rdata = 16'hCAFE;
      #1;
      chk_access("ign.a1", 1'b0, 16'h0401, 16'h5555, 3'd2, 1'b1, 16'hCAFE);
      step();
      mem_ack   = 1'b0;
      start     = 1'b1;
      base_addr = 16'h0900;
      reg_mask  = 8'h01;
      #1;
      chk_quiet("ign.done", 1'b1, 1'b1, 1'b1);
      step();
      start = 1'b0;
      #1;
      chk_quiet("ign.after_done", 1'b0, 1'b0, 1'b0);
      check("ign.after_state", 16'(dbg_state), 16'd0);
      check("final.r0", rf_mem[0], 16'h1111);
      check("final.r1", rf_mem[1], 16'hBEEF);
      check("final.r2", rf_mem[2], 16'hCAFE);
      check("final.r3", rf_mem[3], 16'h3333);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 The block SHALL have the following ports; all are synchronous to clk except reset_n.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request from the decode/register-read stage for an LM/SM instruction.
REQ-005 is_store  in  1  1 = SM (register to memory), 0 = LM (memory to register); sampled with start.
REQ-006 base_addr  in  16  contents of Ra; sampled with start.
REQ-007 reg_mask  in  8  bit i selects register Ri; sampled with start.
REQ-008 mem_ack  in  1  data memory completes the current access this cycle.
REQ-009 mem_rdata  in  16  data memory read data, valid when mem_ack=1.
REQ-010 rf_rdata  in  16  register-file read data for rf_addr (combinational).
REQ-011 busy  out  1  sequence in progress.
REQ-012 stall  out  1  freeze fetch/decode and upstream pipeline registers.
REQ-013 mem_req, mem_we  out  1 each  memory access request and write enable.
REQ-014 mem_addr, mem_wdata  out  16 each  memory address and write data.
REQ-015 rf_addr  out  3  register index (read for SM, write for LM).
REQ-016 rf_we  out  1, rf_wdata  out  16  register-file write port.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 States SHALL be IDLE, ACCESS, DONE.
REQ-019 IDLE: on start=1 with reg_mask!=0, the block SHALL latch is_store, base_addr into addr_ptr and reg_mask into rem_mask, then enter ACCESS.
REQ-020 IDLE: on start=1 with reg_mask=0, the block SHALL enter DONE without any memory or register access.
REQ-021 stall SHALL equal busy OR (state=IDLE AND start), combinationally, so the pipeline freezes in the start cycle.
REQ-022 busy SHALL be 1 in ACCESS and DONE, 0 in IDLE.
REQ-023 ACCESS: rf_addr SHALL be the index of the lowest set bit of rem_mask; mem_req=1; mem_addr=addr_ptr; mem_we=is_store; mem_wdata=rf_rdata.
REQ-024 ACCESS: all request outputs SHALL hold stable until mem_ack=1; no wait-cycle limit.
REQ-025 On mem_ack=1 in LM, rf_we SHALL be 1 in that same cycle with rf_wdata=mem_rdata; rf_we SHALL be 0 in all other cycles and always in SM.
REQ-026 On mem_ack=1, the selected bit SHALL be cleared from rem_mask and addr_ptr incremented by 1 modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-027 On mem_ack=1, if the updated rem_mask is zero the block SHALL enter DONE, else remain in ACCESS for the next register with no idle cycle.
REQ-028 Registers SHALL be accessed in ascending index order at consecutive ascending addresses, one access per set mask bit.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; a start in the DONE cycle SHALL be ignored.
REQ-030 start while busy=1 SHALL be ignored and SHALL not alter latched operands.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.
REQ-032 Outside ACCESS, mem_req, mem_we and rf_we SHALL be 0; mem_addr, mem_wdata, rf_wdata SHALL be 0.

Reset
REQ-033 reset_n=0 SHALL immediately force state IDLE, rem_mask=0, addr_ptr=0 and every output to 0, including mid-sequence; no further access SHALL be issued after reset.
REQ-034 After reset_n rises, the first start SHALL be accepted on the next rising clock edge.

Verification
REQ-035 LM, base 0x0010, mask 0x05, mem_ack every cycle, rdata 0xAAAA then 0x5555 -> R0<=0xAAAA @0x0010, R2<=0x5555 @0x0011, done 2 cycles after ACCESS entry, stall high start to DONE.
REQ-036 SM, base 0x0100, mask 0x81, mem_ack delayed 3 cycles per access -> writes R0 then R7 to 0x0100/0x0101, outputs stable during wait, rf_we never 1.
REQ-037 LM, base 0xFFFF, mask 0x03 -> addresses 0xFFFF then 0x0000.
REQ-038 start with mask 0x00 -> no mem_req, done one cycle after start, stall high for the start and DONE cycles only.
REQ-039 SM mask 0xFF, reset_n low after the third ack -> all outputs 0 asynchronously, no further mem_req; subsequent start processes normally.
REQ-040 Second start asserted mid-sequence with different operands -> ignored; original sequence completes unchanged.
